// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment display path: segment codes and the
// BCD-to-segment lookup table (active-low, bit order {g,f,e,d,c,b,a}).
package disp_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Codes 10..15 are not BCD and render as a dash.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_DASH,   SEG_DASH,
    SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
  import disp_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [6:0]       seg_n
);

  // Table lookup covers all 16 codes, so no code is left undecoded.
  always_comb begin
    seg_n = SEG_LUT[code];
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with one blank cycle per
// digit slot, optional leading-zero blanking and a sticky overflow LED.
module bcd_display_scanner
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        carry_in,
  input  logic                        clr_ovf,
  output logic [6:0]                  seg_n,
  output logic                        dp_n,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic                        ovf_led
);

  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]          presc_q, presc_d;
  logic [IDX_W-1:0]            index_q, index_d;
  logic [BCD_W*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]       dp_sh_q, dp_sh_d;
  logic                        ovf_q, ovf_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;

  logic                        tick_s;
  logic [NUM_DIGITS-1:0]       zero_above_s;
  logic [BCD_W-1:0]            digit_sel_s;
  logic                        dp_sel_s;
  logic                        lz_sel_s;
  logic [NUM_DIGITS-1:0]       an_sel_s;
  logic [6:0]                  dec_seg_s;

  bcd_to_7seg u_dec (
    .code  (digit_sel_s),
    .seg_n (dec_seg_s)
  );

  // Prescaler, digit index, shadow capture and overflow flag next-state.
  always_comb begin
    tick_s = (presc_q == PRESC_LAST);
    if (tick_s) begin
      presc_d = '0;
      if (index_q == IDX_LAST) begin
        index_d = '0;
      end else begin
        index_d = index_q + IDX_W'(1);
      end
    end else begin
      presc_d = presc_q + PRESC_W'(1);
      index_d = index_q;
    end

    if (load) begin
      shadow_d = digits_in;
      dp_sh_d  = dp_in;
    end else begin
      shadow_d = shadow_q;
      dp_sh_d  = dp_sh_q;
    end

    // Set wins over clear so a carry coincident with a clear is never lost.
    if (carry_in) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // zero_above_s[i] is set when every digit from the top down to i is zero.
  always_comb begin
    logic z;
    z = 1'b1;
    zero_above_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (shadow_q[BCD_W*i +: BCD_W] == 4'd0);
      zero_above_s[i] = z;
    end
  end

  // Select the digit addressed by the post-update index and form the outputs.
  always_comb begin
    digit_sel_s = '0;
    dp_sel_s    = 1'b0;
    lz_sel_s    = 1'b0;
    an_sel_s    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_d == IDX_W'(i)) begin
        digit_sel_s = shadow_q[BCD_W*i +: BCD_W];
        dp_sel_s    = dp_sh_q[i];
        lz_sel_s    = (BLANK_LZ != 0) && (i != 0) && zero_above_s[i];
        an_sel_s[i] = 1'b0;
      end else begin
        an_sel_s[i] = 1'b1;
      end
    end

    if (tick_s) begin
      seg_d = SEG_BLANK;
      an_d  = '1;
      dpn_d = 1'b1;
    end else begin
      seg_d = lz_sel_s ? SEG_BLANK : dec_seg_s;
      an_d  = an_sel_s;
      dpn_d = ~dp_sel_s;
    end
  end

  // State and output registers; reset overrides load, carry and tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      index_q  <= '0;
      shadow_q <= '0;
      dp_sh_q  <= '0;
      ovf_q    <= 1'b0;
      seg_q    <= SEG_BLANK;
      dpn_q    <= 1'b1;
      an_q     <= '1;
    end else begin
      presc_q  <= presc_d;
      index_q  <= index_d;
      shadow_q <= shadow_d;
      dp_sh_q  <= dp_sh_d;
      ovf_q    <= ovf_d;
      seg_q    <= seg_d;
      dpn_q    <= dpn_d;
      an_q     <= an_d;
    end
  end

  assign seg_n   = seg_q;
  assign dp_n    = dpn_q;
  assign an_n    = an_q;
  assign ovf_led = ovf_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: a slot-position model predicts each
// cycle's outputs into a scoreboard queue, compared after the clock edge.
module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int RD = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [4*ND-1:0] digits_in;
  logic            load;
  logic [ND-1:0]   dp_in;
  logic            carry_in;
  logic            clr_ovf;
  logic [6:0]      seg_n;
  logic            dp_n;
  logic [ND-1:0]   an_n;
  logic            ovf_led;

  bcd_display_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_LZ    (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .load      (load),
    .dp_in     (dp_in),
    .carry_in  (carry_in),
    .clr_ovf   (clr_ovf),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .ovf_led   (ovf_led)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: {an_n, seg_n, dp_n, ovf_led}
  logic [12:0] sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state: edges since reset release, shadow digits, dp shadow, flag.
  int         m_k;
  logic [3:0] m_dig [ND];
  logic [ND-1:0] m_dp;
  logic       m_ovf;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic ld,
                     input logic [4*ND-1:0] din, input logic [ND-1:0] dpi,
                     input logic cin, input logic clr);
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    logic        ovf_e;
    logic        all_zero;
    logic [12:0] exp_v;
    logic [12:0] obs_v;
    int          idx;
    reset = rst; load = ld; digits_in = din; dp_in = dpi;
    carry_in = cin; clr_ovf = clr;
    if (rst) begin
      an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1; ovf_e = 1'b0;
    end else begin
      ovf_e = cin ? 1'b1 : (clr ? 1'b0 : m_ovf);
      if ((m_k % RD) == RD - 1) begin
        an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
      end else begin
        idx = (m_k / RD) % ND;
        an_e = 4'hF;
        an_e[idx] = 1'b0;
        all_zero = 1'b1;
        for (int j = idx; j < ND; j++) all_zero &= (m_dig[j] == 4'd0);
        seg_e = (idx != 0 && all_zero) ? 7'h7F : seg_of(m_dig[idx]);
        dp_e = ~m_dp[idx];
      end
    end
    sb_q.push_back({an_e, seg_e, dp_e, ovf_e});
    if (rst) begin
      m_k = 0; m_dp = '0; m_ovf = 1'b0;
      for (int j = 0; j < ND; j++) m_dig[j] = 4'd0;
    end else begin
      m_k++;
      m_ovf = ovf_e;
      if (ld) begin
        for (int j = 0; j < ND; j++) m_dig[j] = din[4*j +: 4];
        m_dp = dpi;
      end
    end
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    obs_v = {an_n, seg_n, dp_n, ovf_led};
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s k=%0d an/seg/dp/ovf observed=%b_%b_%b_%b expected=%b_%b_%b_%b",
             tag, m_k, obs_v[12:9], obs_v[8:2], obs_v[1], obs_v[0],
             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
  endtask

  // Idle until the next edge falls at the given position in the 16-cycle frame.
  task automatic idle_to(input string tag, input int pos);
    for (int i = 0; i < 4 * RD * ND; i++) begin
      if ((m_k % (RD * ND)) == pos) break;
      cyc(tag, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    m_k = 0; m_dp = '0; m_ovf = 1'b0;
    for (int j = 0; j < ND; j++) m_dig[j] = 4'd0;
    #2;
    cyc("reset", 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    cyc("reset", 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);

    cyc("load1234", 1'b0, 1'b1, 16'h1234, 4'h0, 1'b0, 1'b0);
    idle("scan1234", 2 * RD * ND);

    cyc("lz_0070", 1'b0, 1'b1, 16'h0070, 4'h0, 1'b0, 1'b0);
    idle("lz_0070", RD * ND + 2);
    cyc("lz_0000", 1'b0, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0);
    idle("lz_0000", RD * ND + 2);

    cyc("dash", 1'b0, 1'b1, 16'h000B, 4'h0, 1'b0, 1'b0);
    idle("dash", RD * ND);

    cyc("dp", 1'b0, 1'b1, 16'h9085, 4'b0101, 1'b0, 1'b0);
    idle("dp", RD * ND);

    cyc("ovf_set", 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    idle("ovf_hold", 3);
    cyc("ovf_multi", 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    cyc("ovf_multi", 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    cyc("ovf_both", 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b1);
    idle("ovf_hold", 2);
    cyc("ovf_clr", 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
    idle("ovf_clr", 2);

    cyc("pre_rst", 1'b0, 1'b1, 16'h4321, 4'h0, 1'b1, 1'b0);
    idle_to("to_dig2", 2 * RD + 1);
    cyc("mid_reset", 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    idle("post_reset", RD + 2);

    cyc("track", 1'b0, 1'b1, 16'h1111, 4'h0, 1'b0, 1'b0);
    cyc("track", 1'b0, 1'b1, 16'h2222, 4'h0, 1'b0, 1'b0);
    cyc("track", 1'b0, 1'b1, 16'h3333, 4'h0, 1'b0, 1'b0);
    cyc("track", 1'b0, 1'b1, 16'h5678, 4'h0, 1'b0, 1'b0);
    idle_to("to_dig0", 1);
    cyc("midslot_ld", 1'b0, 1'b1, 16'h0009, 4'h1, 1'b0, 1'b0);
    idle("midslot_ld", RD * ND);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
